// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared constants and the IF/ID pipeline record for the MIPS core.
// Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int unsigned c_XLEN         = 32;
  localparam logic [31:0] c_NOP_INST     = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] c_RESET_PC     = 32'h0000_0000;

  // IF/ID pipeline register contents, consumed by decode
  typedef struct packed {
    logic [c_XLEN-1:0] inst;
    logic [c_XLEN-1:0] pc4;
    logic              valid;
  } ifid_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : fetch_skid_buf
// Brief   : One-entry hold buffer that parks an in-flight instruction while
//           decode is stalled, so it is not lost when the PC holds.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,    // drop contents (redirect)
  input  logic              i_capture,  // load when empty
  input  logic              i_drain,    // contents consumed this edge
  input  logic [c_XLEN-1:0] i_inst,
  input  logic [c_XLEN-1:0] i_pc,
  output logic              o_valid,
  output logic [c_XLEN-1:0] o_inst,
  output logic [c_XLEN-1:0] o_pc
);

  logic              r_valid;
  logic [c_XLEN-1:0] r_inst;
  logic [c_XLEN-1:0] r_pc;

  // Flush beats capture; a full buffer ignores further captures
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pc    <= '0;
    end else if (i_capture && !r_valid) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Brief   : MIPS IF stage: PC register, synchronous imem addressing and the
//           IF/ID register, with stall absorption and branch redirect.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_RESET_PC,
  parameter logic [31:0] NOP_INST = c_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ifid_inst_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic [31:0] pc_o
);

  logic [31:0] r_pc;
  logic [31:0] r_resp_pc;     // address whose data is on imem_rdata_i now
  logic        r_resp_valid;
  ifid_t       r_ifid;

  logic        w_hold_valid;
  logic [31:0] w_hold_inst;
  logic [31:0] w_hold_pc;
  logic        w_src_valid;
  logic [31:0] w_src_inst;
  logic [31:0] w_src_pc;
  logic [31:0] w_target_pc;
  logic [1:0]  w_unused_bits;

  assign w_target_pc   = {redirect_pc_i[31:2], 2'b00};
  assign w_unused_bits = redirect_pc_i[1:0];

  // Parked instruction takes precedence over the live memory response
  assign w_src_valid = w_hold_valid ? 1'b1        : r_resp_valid;
  assign w_src_inst  = w_hold_valid ? w_hold_inst : imem_rdata_i;
  assign w_src_pc    = w_hold_valid ? w_hold_pc   : r_resp_pc;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (redirect_i),
    .i_capture (stall_i && !redirect_i && r_resp_valid),
    .i_drain   (!stall_i && !redirect_i),
    .i_inst    (imem_rdata_i),
    .i_pc      (r_resp_pc),
    .o_valid   (w_hold_valid),
    .o_inst    (w_hold_inst),
    .o_pc      (w_hold_pc)
  );

  // PC sequencing and IF/ID capture; priority rst > redirect > stall > run
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_resp_pc    <= '0;
      r_resp_valid <= 1'b0;
      r_ifid       <= '{inst: NOP_INST, pc4: 32'h0, valid: 1'b0};
    end else if (redirect_i) begin
      r_pc         <= w_target_pc;
      r_resp_valid <= 1'b0;
      r_ifid       <= '{inst: NOP_INST, pc4: 32'h0, valid: 1'b0};
    end else if (stall_i) begin
      // The re-read of the held PC is discarded; it is fetched again later
      r_resp_valid <= 1'b0;
    end else begin
      r_ifid.inst  <= w_src_valid ? w_src_inst : NOP_INST;
      r_ifid.pc4   <= w_src_pc + 32'd4;
      r_ifid.valid <= w_src_valid;
      r_resp_valid <= 1'b1;
      r_resp_pc    <= r_pc;
      r_pc         <= r_pc + 32'd4;
    end
  end

  assign imem_addr_o  = r_pc;
  assign pc_o         = r_pc;
  assign ifid_inst_o  = r_ifid.inst;
  assign ifid_pc4_o   = r_ifid.pc4;
  assign ifid_valid_o = r_ifid.valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Self-checking bench for fetch_stage (directed vector table plus
//           a wrap-around / reset-during-stall sequence on a second instance).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory contents: word at byte address a is 0x1000_0000 + a/4
  function automatic logic [31:0] f_mem(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  // ---------------- instance 1: RESET_PC = 0 -----------------------------
  logic        rst1 = 1'b1, stall1 = 1'b0, redir1 = 1'b0;
  logic [31:0] rpc1 = '0;
  logic [31:0] addr1, rdata1 = '0, inst1, pc4_1, pc1;
  logic        valid1;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) u_dut1 (
    .clk(clk), .rst(rst1), .stall_i(stall1), .redirect_i(redir1),
    .redirect_pc_i(rpc1), .imem_addr_o(addr1), .imem_rdata_i(rdata1),
    .ifid_inst_o(inst1), .ifid_pc4_o(pc4_1), .ifid_valid_o(valid1), .pc_o(pc1)
  );
  always @(posedge clk) rdata1 <= f_mem(addr1);

  // ---------------- instance 2: RESET_PC = 0xFFFF_FFF8 -------------------
  logic        rst2 = 1'b1, stall2 = 1'b0, redir2 = 1'b0;
  logic [31:0] rpc2 = '0;
  logic [31:0] addr2, rdata2 = '0, inst2, pc4_2, pc2;
  logic        valid2;

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INST(32'h0000_0000)) u_dut2 (
    .clk(clk), .rst(rst2), .stall_i(stall2), .redirect_i(redir2),
    .redirect_pc_i(rpc2), .imem_addr_o(addr2), .imem_rdata_i(rdata2),
    .ifid_inst_o(inst2), .ifid_pc4_o(pc4_2), .ifid_valid_o(valid2), .pc_o(pc2)
  );
  always @(posedge clk) rdata2 <= f_mem(addr2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        chk_pc4;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic s, input logic d,
                              input logic [31:0] rp, input logic [31:0] a,
                              input logic v, input logic [31:0] p4_of_inst,
                              input logic cp);
    vec_t x;
    x.rst = r; x.stall = s; x.redir = d; x.rpc = rp; x.addr = a; x.valid = v;
    // Expected instruction is the one fetched from (pc4 - 4), else a NOP
    x.inst = v ? f_mem(p4_of_inst - 32'd4) : 32'h0000_0000;
    x.pc4 = p4_of_inst; x.chk_pc4 = cp;
    return x;
  endfunction

  initial begin
    // rst stall redir rpc        addr    valid pc4    chk_pc4
    vt.push_back(mk(1,0,0,32'h0 ,32'h00,0,32'h00,1));  // reset
    vt.push_back(mk(1,0,0,32'h0 ,32'h00,0,32'h00,1));
    vt.push_back(mk(0,0,0,32'h0 ,32'h04,0,32'h00,0));  // bubble, latency 2
    vt.push_back(mk(0,0,0,32'h0 ,32'h08,1,32'h04,1));  // inst@0
    vt.push_back(mk(0,0,0,32'h0 ,32'h0C,1,32'h08,1));
    vt.push_back(mk(0,0,0,32'h0 ,32'h10,1,32'h0C,1));  // IF/ID = inst@8
    vt.push_back(mk(0,1,0,32'h0 ,32'h10,1,32'h0C,1));  // single stall
    vt.push_back(mk(0,0,0,32'h0 ,32'h14,1,32'h10,1));  // inst@C from hold
    vt.push_back(mk(0,0,0,32'h0 ,32'h18,1,32'h14,1));  // inst@10 re-fetched
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0,1,0,32'h0,32'h18,1,32'h14,1)); // 5-cycle stall
    vt.push_back(mk(0,0,0,32'h0 ,32'h1C,1,32'h18,1));
    vt.push_back(mk(0,0,0,32'h0 ,32'h20,1,32'h1C,1));
    vt.push_back(mk(0,0,0,32'h0 ,32'h24,1,32'h20,1));
    vt.push_back(mk(0,0,1,32'h43,32'h40,0,32'h00,0));  // redirect, low bits dropped
    vt.push_back(mk(0,0,0,32'h0 ,32'h44,0,32'h00,0));
    vt.push_back(mk(0,0,0,32'h0 ,32'h48,1,32'h44,1));  // inst@40
    vt.push_back(mk(0,0,0,32'h0 ,32'h4C,1,32'h48,1));
    vt.push_back(mk(0,1,0,32'h0 ,32'h4C,1,32'h48,1));  // hold fills with inst@48
    vt.push_back(mk(0,1,0,32'h0 ,32'h4C,1,32'h48,1));
    vt.push_back(mk(0,1,1,32'h80,32'h80,0,32'h00,0));  // redirect wins over stall
    vt.push_back(mk(0,0,0,32'h0 ,32'h84,0,32'h00,0));  // held inst discarded
    vt.push_back(mk(0,0,0,32'h0 ,32'h88,1,32'h84,1));  // inst@80
    vt.push_back(mk(0,0,0,32'h0 ,32'h8C,1,32'h88,1));

    // Instance 2 sits in reset while the table runs
    for (int i = 0; i < vt.size(); i++) begin
      rst1 = vt[i].rst; stall1 = vt[i].stall; redir1 = vt[i].redir; rpc1 = vt[i].rpc;
      @(posedge clk); #1;
      chk($sformatf("v%0d addr", i),  addr1, vt[i].addr);
      chk($sformatf("v%0d pc_o", i),  pc1,   vt[i].addr);
      chk($sformatf("v%0d valid", i), {31'b0, valid1}, {31'b0, vt[i].valid});
      chk($sformatf("v%0d inst", i),  inst1, vt[i].inst);
      if (vt[i].chk_pc4) chk($sformatf("v%0d pc4", i), pc4_1, vt[i].pc4);
    end
    rst1 = 1'b1; stall1 = 1'b0; redir1 = 1'b0;

    // Wrap-around free run on instance 2
    chk("wrap reset addr", addr2, 32'hFFFF_FFF8);
    chk("wrap reset valid", {31'b0, valid2}, 32'h0);
    rst2 = 1'b0;
    @(posedge clk); #1;
    chk("wrap e1 addr", addr2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap e2 addr", addr2, 32'h0000_0000);
    chk("wrap e2 inst", inst2, f_mem(32'hFFFF_FFF8));
    chk("wrap e2 pc4",  pc4_2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap e3 addr", addr2, 32'h0000_0004);
    chk("wrap e3 inst", inst2, f_mem(32'hFFFF_FFFC));
    chk("wrap e3 pc4",  pc4_2, 32'h0000_0000);
    chk("wrap e3 valid", {31'b0, valid2}, 32'h1);

    // Reset asserted in the middle of a stall
    stall2 = 1'b1;
    @(posedge clk); #1;
    chk("stall hold addr", addr2, 32'h0000_0004);
    chk("stall hold inst", inst2, f_mem(32'hFFFF_FFFC));
    rst2 = 1'b1;
    @(posedge clk); #1;
    chk("rst mid-stall addr",  addr2, 32'hFFFF_FFF8);
    chk("rst mid-stall pc_o",  pc2,   32'hFFFF_FFF8);
    chk("rst mid-stall valid", {31'b0, valid2}, 32'h0);
    chk("rst mid-stall inst",  inst2, 32'h0000_0000);
    chk("rst mid-stall pc4",   pc4_2, 32'h0000_0000);
    stall2 = 1'b0;

    // Hold buffer must have been cleared by reset: no stale instruction
    rst2 = 1'b0;
    @(posedge clk); #1;
    chk("post-rst e1 valid", {31'b0, valid2}, 32'h0);
    @(posedge clk); #1;
    chk("post-rst e2 inst", inst2, f_mem(32'hFFFF_FFF8));
    chk("post-rst e2 pc4",  pc4_2, 32'hFFFF_FFFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch (IF) stage of the 5-stage MIPS pipeline. It sits directly upstream of decode. It owns the PC register and drives the synchronous instruction memory address. It captures the returned instruction into the IF/ID pipeline register and absorbs decode stalls and branch redirects without losing or duplicating instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
NOP_INST, 32'h0000_0000, instruction word driven on ifid_inst_o when the slot is a bubble (sll $0,$0,0).

Ports:
clk  in  1  single clock; all state updates on posedge.
rst  in  1  reset; synchronous, active-high.
stall_i  in  1  hazard unit requests that IF/ID and the PC hold.
redirect_i  in  1  taken branch; the younger fetch stream is flushed.
redirect_pc_i  in  32  branch target; bits [1:0] are ignored and forced to 0.
imem_addr_o  out  32  byte address presented to instruction memory; equals pc_q (combinational from register).
imem_rdata_i  in  32  instruction memory data; valid in the cycle after the address was presented (memory registers on posedge).
ifid_inst_o  out  32  IF/ID instruction.
ifid_pc4_o  out  32  IF/ID PC+4 of that instruction.
ifid_valid_o  out  1  IF/ID slot holds a real instruction.
pc_o  out  32  current pc_q, for debug and monitor.

Behaviour:
Interface constraint (already decided): one clock; reset is synchronous and active-high.

Reset:
- On a posedge with rst=1: pc_q=RESET_PC, resp_valid_q=0, hold_valid_q=0, ifid_valid_o=0, ifid_inst_o=NOP_INST, ifid_pc4_o=0.
- rst has priority over every other input, including mid-stall and mid-redirect.

Internal state:
- pc_q: address being presented this cycle.
- resp_valid_q / resp_pc_q: tag for the data on imem_rdata_i this cycle.
- hold_valid_q / hold_inst_q / hold_pc_q: one-entry skid buffer.

Per-edge priority: rst > redirect_i > stall_i > normal.

Redirect (redirect_i=1, regardless of stall_i):
- pc_q <= {redirect_pc_i[31:2],2'b00}.
- resp_valid_q <= 0 and hold_valid_q <= 0.
- IF/ID becomes a bubble: ifid_valid_o=0, ifid_inst_o=NOP_INST.
- The first target instruction reaches IF/ID 2 edges after the redirect edge, absent further stalls.

Stall (stall_i=1, redirect_i=0):
- pc_q and IF/ID registers hold.
- If resp_valid_q=1 and hold_valid_q=0: hold <= {imem_rdata_i, resp_pc_q}, hold_valid_q <= 1.
- resp_valid_q <= 0, so the re-read of the held pc_q is discarded. The address is re-fetched after release.

Normal (both low):
- Source for IF/ID: hold buffer if hold_valid_q, else the response (valid = resp_valid_q).
- IF/ID captures inst, pc4 = source_pc + 4, and valid.
- hold_valid_q <= 0; resp_valid_q <= 1; resp_pc_q <= pc_q; pc_q <= pc_q + 4.

Arithmetic: all PC arithmetic is 32-bit modulo 2^32, so 0xFFFF_FFFC + 4 = 0x0000_0000.

Throughput and latency:
- Steady state delivers one instruction per cycle.
- An instruction presented at edge k appears in IF/ID after edge k+2.
- A stall of N cycles inserts no bubble and drops no instruction.

No combinational path from stall_i or redirect_i to any output.

Decomposition:
- mips_pkg holds: XLEN=32, NOP_INST, RESET_PC default, and a packed struct ifid_t {inst, pc4, valid} shared with decode.
- One natural sub-module: fetch_skid_buf, the one-entry hold buffer with capture/drain/flush controls.
- The PC register and sequencing stay in fetch_stage.

Test Plan:
1. Reset then free-run, mem[i]=0x1000_0000+i, with 2 edges of rst=1 then rst=0 -> imem_addr_o 0,4,8..., each +4 per cycle; ifid_inst_o=0x1000_0000 with pc4=4 after the 2nd non-reset edge, then 0x1000_0001 with pc4=8; ifid_valid_o=0 before that.
2. Single stall while IF/ID holds inst@0x8 -> IF/ID holds for 1 cycle; the next edges yield inst@0xC then inst@0x10 with no bubble or duplicate; imem_addr_o repeats 0x10 once.
3. Stall held 5 cycles -> IF/ID and pc_o constant for 5 cycles; after release the sequence continues exactly in order with no gaps.
4. redirect_i=1 with redirect_pc_i=0x0000_0043 -> pc_o=0x40 next cycle; ifid_valid_o=0 for 2 cycles; then inst@0x40 with pc4=0x44.
5. redirect_i=1 and stall_i=1 on the same edge while the hold buffer is full -> the redirect wins; the held instruction never reaches IF/ID; the target arrives 2 edges later.
6. RESET_PC=0xFFFF_FFF8 with free-run -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; ifid_pc4_o for the 0xFFFF_FFFC instruction is 0x0. Asserting rst mid-stall returns all outputs to reset values on the next edge.
